// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-wide data memory; sub-word stores are read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned requests are answered with resp_err instead of being aligned down.
module load_store_unit #(
    parameter int MEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write_en,
    output logic [31:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_addr,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [31:0] ADDR_MASK = 32'(MEM_SIZE - 1);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        mem_write_en_q, mem_write_en_d;
    logic [31:0] mem_write_data_q, mem_write_data_d;
    logic [31:0] waddr_s;
    logic        trap_s;

    // Select the addressed lane (little-endian) and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic sgn, input logic [1:0] lane);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] result;
        byte_v = 8'(word >> {lane, 3'b000});
        half_v = 16'(word >> {lane[1], 4'b0000});
        case (size)
            2'b00:   result = sgn ? {{24{byte_v[7]}}, byte_v} : {24'h00_0000, byte_v};
            2'b01:   result = sgn ? {{16{half_v[15]}}, half_v} : {16'h0000, half_v};
            default: result = word;
        endcase
        return result;
    endfunction

    // Replace only the addressed lane of the read word with the low store bits.
    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic [31:0] wdata);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                data = {24'h00_0000, wdata[7:0]} << {lane, 3'b000};
            end
            2'b01: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                data = {16'h0000, wdata[15:0]} << {lane[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                data = wdata;
            end
        endcase
        return (word & ~mask) | (data & mask);
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic mis;
        case (size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = lane[0];
            default: mis = (lane != 2'b00);
        endcase
        return mis;
    endfunction

    assign trap_s = is_misaligned(req_size, req_addr[1:0]);
`else
    assign trap_s = 1'b0;
`endif

    assign waddr_s        = addr_q & ADDR_MASK & 32'hFFFF_FFFC;
    assign mem_read_addr  = waddr_s;
    assign mem_write_addr = waddr_s;
    assign req_ready      = (state_q == S_IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_write_en   = mem_write_en_q;
    assign mem_write_data = mem_write_data_q;

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d          = state_q;
        we_d             = we_q;
        size_d           = size_q;
        signed_d         = signed_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        resp_valid_d     = 1'b0;
        resp_rdata_d     = resp_rdata_q;
        resp_err_d       = 1'b0;
        mem_write_en_d   = 1'b0;
        mem_write_data_d = mem_write_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    size_d   = req_size;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (trap_s) begin
                        state_d = S_ERR;
                    end else if (req_we && req_size[1]) begin
                        // Full-word store needs no read; write strobe rises with WRITE.
                        state_d          = S_WRITE;
                        mem_write_en_d   = 1'b1;
                        mem_write_data_d = req_wdata;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (we_q) begin
                    state_d          = S_WRITE;
                    mem_write_en_d   = 1'b1;
                    mem_write_data_d = merge_store(mem_read_data, size_q, addr_q[1:0], wdata_q);
                end else begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = extract_load(mem_read_data, size_q, signed_q, addr_q[1:0]);
                end
            end
            S_WRITE: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = 32'h0000_0000;
            end
            S_ERR: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_rdata_d = 32'h0000_0000;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            we_q             <= 1'b0;
            size_q           <= 2'b00;
            signed_q         <= 1'b0;
            addr_q           <= 32'h0000_0000;
            wdata_q          <= 32'h0000_0000;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= 32'h0000_0000;
            resp_err_q       <= 1'b0;
            mem_write_en_q   <= 1'b0;
            mem_write_data_q <= 32'h0000_0000;
        end else begin
            state_q          <= state_d;
            we_q             <= we_d;
            size_q           <= size_d;
            signed_q         <= signed_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_err_q       <= resp_err_d;
            mem_write_en_q   <= mem_write_en_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;

    localparam int MEM_SIZE = 4096;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write_en;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;

    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;
    logic [31:0] ram [0:1023];
    logic [7:0]  ref_mem [0:MEM_SIZE-1];

    typedef struct { logic [31:0] rdata; logic err; int cyc; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    resp_t rq[$];
    wr_t   wq[$];

    int cyc;
    int checks;
    int errors;
    int accepted;
    int responded;
    int aborted;

    load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
        .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory with registered read port and a preload path for the bench.
    always @(posedge clk) begin
        if (pre_we) ram[pre_idx] <= pre_data;
        else if (mem_write_en) ram[mem_write_addr[11:2]] <= mem_write_data;
        mem_read_data <= ram[mem_read_addr[11:2]];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : ((size == 2'b01) ? 2 : 4);
    endfunction

    function automatic int base_of(input logic [31:0] addr, input int n);
        logic [31:0] a;
        a = addr & 32'(MEM_SIZE - 1);
        a = a & ~32'(n - 1);
        return int'(a);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
        int n;
        int b;
        logic [31:0] v;
        n = nbytes(size);
        b = base_of(addr, n);
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[b + i]) << (8 * i));
        if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic set_word(input logic [31:0] addr, input logic [31:0] val);
        pre_we = 1'b1;
        pre_idx = addr[11:2];
        pre_data = val;
        for (int i = 0; i < 4; i++) ref_mem[base_of(addr, 4) + i] = 8'(val >> (8 * i));
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // Present a request, wait for acceptance, and record the expected outcome.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit abort);
        int waited;
        int n;
        int b;
        int now;
        bit trap;
        resp_t r;
        wr_t w;
        req_valid = 1'b1;
        req_we = we;
        req_size = size;
        req_signed = sgn;
        req_addr = addr;
        req_wdata = wdata;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout ready %b expected 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        now = cyc;
        n = nbytes(size);
        b = base_of(addr, n);
`ifdef MISALIGN_TRAP_EN
        trap = (int'(addr[1:0]) % n) != 0;
`else
        trap = 1'b0;
`endif
        r.err = 1'b0;
        r.rdata = 32'h0;
        if (trap) begin
            r.err = 1'b1;
            r.cyc = now + 2;
        end else if (!we) begin
            r.rdata = ref_load(addr, size, sgn);
            r.cyc = now + 3;
        end else begin
            r.cyc = now + ((n == 4) ? 2 : 4);
            if (!abort) for (int i = 0; i < n; i++) ref_mem[b + i] = 8'(wdata >> (8 * i));
            w.addr = 32'(base_of(addr, 4));
            w.data = ref_load(w.addr, 2'b10, 1'b0);
            if (!abort) wq.push_back(w);
        end
        if (!abort) rq.push_back(r);
        @(posedge clk);
        #1;
        accepted++;
    endtask

    task automatic idle(input int k);
        req_valid = 1'b0;
        repeat (k) @(posedge clk);
        if (k > 0) #1;
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (accepted != responded + aborted && i < 60) begin
            @(posedge clk);
            i++;
        end
        #1;
        check("drain_outstanding", 32'(accepted - responded - aborted), 32'h0);
    endtask

    // Pops expected writes/responses whenever the DUT presents them.
    task automatic monitor();
        resp_t r;
        wr_t w;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_write_en) begin
                    if (wq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write addr %h data %h", mem_write_addr, mem_write_data);
                    end else begin
                        w = wq.pop_front();
                        check("write_addr", mem_write_addr, w.addr);
                        check("write_data", mem_write_data, w.data);
                    end
                end
                if (resp_valid) begin
                    responded++;
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp rdata %h err %b", resp_rdata, resp_err);
                    end else begin
                        r = rq.pop_front();
                        check("resp_rdata", resp_rdata, r.rdata);
                        check("resp_err", 32'(resp_err), 32'(r.err));
                        check("resp_cycle", 32'(cyc), 32'(r.cyc));
                    end
                end
                check("req_ready", 32'(req_ready), 32'(accepted == responded + aborted));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_signed = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        pre_we = 1'b0;
        pre_idx = 10'h0;
        pre_data = 32'h0;
        cyc = 0;
        checks = 0;
        errors = 0;
        accepted = 0;
        responded = 0;
        aborted = 0;
        for (int i = 0; i < 1024; i++) begin
            logic [31:0] v;
            v = $urandom;
            @(negedge clk);
            pre_we = 1'b1;
            pre_idx = 10'(i);
            pre_data = v;
            for (int j = 0; j < 4; j++) ref_mem[4 * i + j] = 8'(v >> (8 * j));
        end
        @(negedge clk);
        pre_we = 1'b0;
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_mem_write_en", 32'(mem_write_en), 32'h0);
        check("rst_mem_read_addr", mem_read_addr, 32'h0);
        check("rst_mem_write_addr", mem_write_addr, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        fork
            monitor();
        join_none

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        idle(1);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        idle(1);
        drain();
        check("word_store_mem", ram[4], 32'hDEADBEEF);

        set_word(32'h20, 32'h11223344);
        set_word(32'h30, 32'h80FF7F01);
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, 1'b0);
        idle(1);
        drain();
        check("byte_store_mem", ram[8], 32'h1122AA44);

        issue(1'b0, 2'b00, 1'b1, 32'h32, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b0, 32'h32, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 1'b0);
        issue(1'b1, 2'b11, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0);
        issue(1'b1, 2'b01, 1'b0, 32'h42, 32'h00001234, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b0);
        idle(0);
        drain();

        // Abort a sub-word store while it waits on read data.
        issue(1'b1, 2'b00, 1'b0, 32'h44, 32'h0000005A, 1'b1);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        aborted++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_resp_valid", 32'(resp_valid), 32'h0);
        check("abort_write_en", 32'(mem_write_en), 32'h0);
        check("abort_read_addr", mem_read_addr, 32'h0);
        @(posedge clk);
        #1;
        issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 1'b0);
        idle(2);

        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
            issue(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, $urandom, 1'b0);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
        end
        idle(0);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("resp_queue_empty", 32'(rq.size()), 32'h0);
        check("write_queue_empty", 32'(wq.size()), 32'h0);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 1024; i++) begin
                if (ram[i] !== ref_load(32'(4 * i), 2'b10, 1'b0)) begin
                    if (bad == 0)
                        $display("FAIL mem_word idx %0d got %h expected %h", i, ram[i],
                                 ref_load(32'(4 * i), 2'b10, 1'b0));
                    bad++;
                end
            end
            checks++;
            if (bad != 0) errors++;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator-side memory access unit between the CPU execute stage and the word-organised data memory.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Drives the memory's single write port and registered read port, and returns sign/zero-extended load data.
- Memory has no byte enables, so sub-word stores are done as read-modify-write (RMW).

Parameters:
- MEM_SIZE, 4096, data memory size in bytes. Must be a power of two, at least 4. Addresses are reduced modulo MEM_SIZE.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- req_signed  input  1  sign-extend sub-word loads
- req_addr  input  32  byte address
- req_wdata  input  32  store data; sub-word data taken from the low bits
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result; 0 for stores
- resp_err  output  1  misaligned-access flag; tied 0 unless MISALIGN_TRAP_EN
- mem_write_en  output  1  memory write strobe
- mem_write_addr  output  32  word-aligned byte address
- mem_write_data  output  32  full word to write
- mem_read_addr  output  32  word-aligned byte address
- mem_read_data  input  32  memory read data, registered, 1-cycle latency

Behaviour:
- Reset
  - state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_write_en=0.
  - Latched request registers cleared, so mem_read_addr=0 and mem_write_addr=0.
  - Reset mid-operation aborts the access: no write issued, no response.
- Handshake
  - Request accepted on a rising edge when req_valid & req_ready; all request fields latched then.
  - Requests are ignored in any other state.
  - No response backpressure: resp_valid is a registered pulse, one cycle only.
  - A new request may be accepted in the same cycle resp_valid is high.
- Address: waddr = {(addr_q mod MEM_SIZE)[31:2], 2'b00}. mem_read_addr and mem_write_addr are both driven from waddr at all times.
- States
  - IDLE
    - Word store goes to WRITE.
    - Load or sub-word store goes to READ.
  - READ: memory samples mem_read_addr at the end of this cycle. Next state WAIT.
  - WAIT: mem_read_data is valid this cycle.
    - Load: extract, register resp_rdata, go to IDLE with resp_valid=1 next cycle.
    - Sub-word store: register the merged word, go to WRITE.
  - WRITE: mem_write_en=1 for exactly one cycle, with mem_write_data = store word or merged word. Next state IDLE, with resp_valid=1 and resp_rdata=0 next cycle.
- Latency (request accepted at edge E0)
  - Load: resp_valid in the 3rd cycle after E0.
  - Word store: resp_valid in the 2nd cycle after E0.
  - Sub-word store: resp_valid in the 4th cycle after E0.
- Byte lanes are little-endian.
  - Byte: lane addr[1:0], bits [8*k+7:8*k].
  - Half: lane addr[1], bits [16*h+15:16*h].
  - Load extension: sign-extend if req_signed, else zero-extend. Word loads ignore req_signed.
- Merge: only the selected lane is replaced with req_wdata[7:0] or req_wdata[15:0]; all other bytes keep the read value.
- Read and write to memory are never issued in the same cycle, so there is no same-address read/write hazard.
- Misalignment (half with addr[0]=1; word with addr[1:0]≠0)
  - Without the feature: low address bits below the access size are ignored, i.e. the access is aligned down.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A misaligned request is accepted, goes to state ERR for 1 cycle, and makes no memory access (mem_write_en stays 0).
  - resp_valid=1 with resp_err=1 and resp_rdata=0 in the 2nd cycle after E0.
  - resp_err is 0 on every other response.
- Undefined: no ERR state, resp_err tied 0, align-down behaviour as above.

Test Plan:
- Word store 0xDEADBEEF @0x10, then word load @0x10 -> store resp 2 cycles after accept, exactly one mem_write_en pulse; load resp_rdata=0xDEADBEEF 3 cycles after accept.
- Mem word @0x20=0x11223344; byte store 0xAA @0x21 -> READ/WAIT/WRITE sequence, mem_write_data=0x1122AA44, resp 4 cycles after accept.
- Mem word @0x30=0x80FF7F01:
  - signed byte load @0x32 -> 0xFFFFFFFF
  - unsigned byte load @0x32 -> 0x000000FF
  - signed half load @0x32 -> 0xFFFF80FF
  - unsigned half load @0x30 -> 0x00007F01
- Back-to-back requests with req_valid held high -> req_ready low in non-IDLE states, second request accepted in the cycle of the first resp_valid, no request lost or duplicated.
- Reset asserted during WAIT of a sub-word store -> no mem_write_en, no resp_valid, memory word unchanged; next request serviced normally.
- With MISALIGN_TRAP_EN, half load @0x03 -> resp_err=1, resp_rdata=0, no memory access. Without the macro, same request -> reads the halfword at 0x02.
